// File: rtl/ibex_pkg.sv
// Shared types and constants for the writeback controller slice.
package ibex_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_PEND = 1'b1
    } wb_state_e;

    // Where the write selected this cycle came from.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_EX   = 2'd1,
        WB_SRC_LOAD = 2'd2
    } wb_src_e;

    // RV32E only implements x0-x15, so any address with the top bit set is illegal.
    function automatic logic rv32e_waddr_illegal(input logic rv32e,
                                                 input logic [REG_ADDR_W-1:0] addr);
        return rv32e & addr[REG_ADDR_W-1];
    endfunction

endpackage

// File: rtl/ibex_rf_wb_ctrl_if.sv
// Pipeline-facing bundle of the writeback controller: execute, load, LSU, ID reads and RF write port.
interface ibex_rf_wb_ctrl_if
    import ibex_pkg::*;
#(
    parameter int DataWidth = 32
);

    logic                  ex_valid_i;
    logic [REG_ADDR_W-1:0] ex_waddr_i;
    logic [DataWidth-1:0]  ex_wdata_i;
    logic                  ex_ready_o;

    logic                  ld_issue_i;
    logic [REG_ADDR_W-1:0] ld_waddr_i;
    logic                  ld_ready_o;

    logic                  lsu_rvalid_i;
    logic [DataWidth-1:0]  lsu_rdata_i;
    logic                  lsu_err_i;

    logic [REG_ADDR_W-1:0] raddr_a_i;
    logic [REG_ADDR_W-1:0] raddr_b_i;
    logic                  hazard_a_o;
    logic                  hazard_b_o;

    logic [REG_ADDR_W-1:0] rf_waddr_o;
    logic [DataWidth-1:0]  rf_wdata_o;
    logic                  rf_we_o;
    logic                  load_err_o;
    logic                  illegal_waddr_o;

    // Pipeline side: drives requests, observes acceptance, hazards and the write port.
    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output ld_issue_i, ld_waddr_i,
        output lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
        output raddr_a_i, raddr_b_i,
        input  ex_ready_o, ld_ready_o,
        input  hazard_a_o, hazard_b_o,
        input  rf_waddr_o, rf_wdata_o, rf_we_o,
        input  load_err_o, illegal_waddr_o
    );

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  ld_issue_i, ld_waddr_i,
        input  lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
        input  raddr_a_i, raddr_b_i,
        output ex_ready_o, ld_ready_o,
        output hazard_a_o, hazard_b_o,
        output rf_waddr_o, rf_wdata_o, rf_we_o,
        output load_err_o, illegal_waddr_o
    );

endinterface

// File: rtl/ibex_rf_hazard_cmp.sv
// Read-after-write hazard check for one register file read port.
module ibex_rf_hazard_cmp
    import ibex_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] raddr_i,
    input  logic                  pend_valid_i,
    input  logic [REG_ADDR_W-1:0] pend_rd_i,
    input  logic                  wr_valid_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    output logic                  hazard_o
);

    logic pend_hit;
    logic wr_hit;

    // x0 is hardwired, so neither term may ever fire for it.
    assign pend_hit = pend_valid_i & (raddr_i == pend_rd_i) & (pend_rd_i != '0);
    assign wr_hit   = wr_valid_i & (raddr_i == wr_addr_i) & (raddr_i != '0);
    assign hazard_o = pend_hit | wr_hit;

endmodule

// File: rtl/ibex_rf_wb_ctrl.sv
// Writeback controller: merges execute results and load data onto the single registered RF write port.
module ibex_rf_wb_ctrl
    import ibex_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter bit RV32E     = 1'b0
) (
    input logic               clk_i,
    input logic               rst_ni,
    ibex_rf_wb_ctrl_if.slave  bus
);

    wb_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0]  rf_wdata_q, rf_wdata_d;
    logic                  load_err_q, load_err_d;
    logic                  illegal_q, illegal_d;

    logic                  pend;
    logic                  ld_resp;
    logic                  ld_ready;
    logic                  waw_stall;
    logic                  ex_ready;
    logic                  ex_fire;

    wb_src_e               wr_src;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DataWidth-1:0]  wr_data;

    assign pend     = (state_q == WB_PEND);
    assign ld_resp  = pend & bus.lsu_rvalid_i;
    assign ld_ready = ~pend | bus.lsu_rvalid_i;

    // Execute may not overtake a load that targets the same register.
    assign waw_stall = pend & (bus.ex_waddr_i == pend_rd_q) & (pend_rd_q != '0);
    assign ex_ready  = ~ld_resp & ~waw_stall;
    assign ex_fire   = bus.ex_valid_i & ex_ready;

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        unique case (state_q)
            WB_IDLE: begin
                if (bus.ld_issue_i) begin
                    state_d   = WB_PEND;
                    pend_rd_d = bus.ld_waddr_i;
                end
            end
            WB_PEND: begin
                // A response retires the current load; a same-cycle issue keeps us pending.
                if (bus.lsu_rvalid_i) begin
                    if (bus.ld_issue_i) begin
                        pend_rd_d = bus.ld_waddr_i;
                    end else begin
                        state_d = WB_IDLE;
                    end
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // Load responses win the port; execute only gets it when no response is present.
    always_comb begin
        wr_src     = WB_SRC_NONE;
        wr_addr    = bus.ex_waddr_i;
        wr_data    = bus.ex_wdata_i;
        load_err_d = 1'b0;
        if (ld_resp) begin
            if (bus.lsu_err_i) begin
                load_err_d = 1'b1;
            end else begin
                wr_src  = WB_SRC_LOAD;
                wr_addr = pend_rd_q;
                wr_data = bus.lsu_rdata_i;
            end
        end else if (ex_fire) begin
            wr_src = WB_SRC_EX;
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        illegal_d  = 1'b0;
        if (wr_src != WB_SRC_NONE) begin
            if (rv32e_waddr_illegal(RV32E, wr_addr)) begin
                illegal_d = 1'b1;
            end else if (wr_addr != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = wr_addr;
                rf_wdata_d = wr_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= WB_IDLE;
            pend_rd_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            load_err_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_rd_q  <= pend_rd_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            load_err_q <= load_err_d;
            illegal_q  <= illegal_d;
        end
    end

    ibex_rf_hazard_cmp u_hazard_a (
        .raddr_i      (bus.raddr_a_i),
        .pend_valid_i (pend),
        .pend_rd_i    (pend_rd_q),
        .wr_valid_i   (rf_we_q),
        .wr_addr_i    (rf_waddr_q),
        .hazard_o     (bus.hazard_a_o)
    );

    ibex_rf_hazard_cmp u_hazard_b (
        .raddr_i      (bus.raddr_b_i),
        .pend_valid_i (pend),
        .pend_rd_i    (pend_rd_q),
        .wr_valid_i   (rf_we_q),
        .wr_addr_i    (rf_waddr_q),
        .hazard_o     (bus.hazard_b_o)
    );

    assign bus.ex_ready_o      = ex_ready;
    assign bus.ld_ready_o      = ld_ready;
    assign bus.rf_we_o         = rf_we_q;
    assign bus.rf_waddr_o      = rf_waddr_q;
    assign bus.rf_wdata_o      = rf_wdata_q;
    assign bus.load_err_o      = load_err_q;
    assign bus.illegal_waddr_o = illegal_q;

`ifndef SYNTHESIS
    // Only one load may be outstanding unless its response retires in the same cycle.
    ld_issue_when_ready: assert property (
        @(posedge clk_i) disable iff (!rst_ni) bus.ld_issue_i |-> ld_ready
    );
`endif

endmodule

// File: tb/tb_ibex_rf_wb_ctrl.sv
// Scoreboard bench for ibex_rf_wb_ctrl: expected RF-port events queued at drive time, popped on output.
module tb_ibex_rf_wb_ctrl;
    import ibex_pkg::*;

    localparam logic [1:0] EV_WR  = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;
    localparam logic [1:0] EV_ILL = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    ibex_rf_wb_ctrl_if #(.DataWidth(32)) bus ();
    ibex_rf_wb_ctrl_if #(.DataWidth(32)) bus_e ();

    ibex_rf_wb_ctrl #(.DataWidth(32), .RV32E(1'b0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    ibex_rf_wb_ctrl #(.DataWidth(32), .RV32E(1'b1)) dut_e (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_e.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        sb_q.push_back('{kind: EV_WR, addr: a, data: d});
    endtask

    task automatic push_ev(input logic [1:0] k);
        sb_q.push_back('{kind: k, addr: 5'd0, data: 32'd0});
    endtask

    task automatic idle();
        bus.ex_valid_i   = 1'b0; bus.ex_waddr_i = '0; bus.ex_wdata_i = '0;
        bus.ld_issue_i   = 1'b0; bus.ld_waddr_i = '0;
        bus.lsu_rvalid_i = 1'b0; bus.lsu_rdata_i = '0; bus.lsu_err_i = 1'b0;
        bus.raddr_a_i    = '0;   bus.raddr_b_i  = '0;
        bus_e.ex_valid_i   = 1'b0; bus_e.ex_waddr_i = '0; bus_e.ex_wdata_i = '0;
        bus_e.ld_issue_i   = 1'b0; bus_e.ld_waddr_i = '0;
        bus_e.lsu_rvalid_i = 1'b0; bus_e.lsu_rdata_i = '0; bus_e.lsu_err_i = 1'b0;
        bus_e.raddr_a_i    = '0;   bus_e.raddr_b_i  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic ex(input logic [4:0] a, input logic [31:0] d);
        bus.ex_valid_i = 1'b1; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
    endtask

    task automatic ld(input logic [4:0] a);
        bus.ld_issue_i = 1'b1; bus.ld_waddr_i = a;
    endtask

    task automatic rsp(input logic [31:0] d, input logic err);
        bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = d; bus.lsu_err_i = err;
    endtask

    // Every RF-port event must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.rf_we_o || bus.load_err_o || bus.illegal_waddr_o)) begin
            logic [1:0] kind;
            exp_t       e;
            kind = bus.rf_we_o ? EV_WR : (bus.load_err_o ? EV_ERR : EV_ILL);
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {30'd0, kind}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("event_kind", {30'd0, kind}, {30'd0, e.kind});
                if (e.kind == EV_WR) begin
                    chk("wr_addr", {27'd0, bus.rf_waddr_o}, {27'd0, e.addr});
                    chk("wr_data", bus.rf_wdata_o, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_we",       {31'd0, bus.rf_we_o}, 32'd0);
        chk("rst_waddr",    {27'd0, bus.rf_waddr_o}, 32'd0);
        chk("rst_wdata",    bus.rf_wdata_o, 32'd0);
        chk("rst_load_err", {31'd0, bus.load_err_o}, 32'd0);
        chk("rst_illegal",  {31'd0, bus.illegal_waddr_o}, 32'd0);
        chk("rst_ld_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        chk("rst_ex_ready", {31'd0, bus.ex_ready_o}, 32'd1);
        tick();
        rst_n = 1'b1;

        // Execute write, registered one cycle, with hazard on the in-flight write.
        tick(); ex(5'd5, 32'hDEADBEEF); settle();
        chk("t1_ex_ready", {31'd0, bus.ex_ready_o}, 32'd1);
        push_wr(5'd5, 32'hDEADBEEF);
        tick(); bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd6; settle();
        chk("t1_hazard_a", {31'd0, bus.hazard_a_o}, 32'd1);
        chk("t1_hazard_b", {31'd0, bus.hazard_b_o}, 32'd0);
        tick(); bus.raddr_a_i = 5'd5; settle();
        chk("t1_hazard_a_clear", {31'd0, bus.hazard_a_o}, 32'd0);
        chk("t1_wdata_hold", bus.rf_wdata_o, 32'hDEADBEEF);

        // Single load, response three cycles after issue.
        tick(); ld(5'd7); settle();
        chk("t2_ld_ready_idle", {31'd0, bus.ld_ready_o}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(); bus.raddr_b_i = 5'd7; settle();
            chk("t2_ld_ready_pend", {31'd0, bus.ld_ready_o}, 32'd0);
            chk("t2_hazard_b_pend", {31'd0, bus.hazard_b_o}, 32'd1);
        end
        tick(); rsp(32'h1234, 1'b0); bus.raddr_b_i = 5'd7; settle();
        chk("t2_ld_ready_rsp", {31'd0, bus.ld_ready_o}, 32'd1);
        chk("t2_hazard_b_rsp", {31'd0, bus.hazard_b_o}, 32'd1);
        push_wr(5'd7, 32'h1234);
        tick(); bus.raddr_b_i = 5'd7; settle();
        chk("t2_hazard_b_wr", {31'd0, bus.hazard_b_o}, 32'd1);
        tick(); bus.raddr_b_i = 5'd7; settle();
        chk("t2_hazard_b_done", {31'd0, bus.hazard_b_o}, 32'd0);

        // WAW stall against the pending load, and load priority on the response cycle.
        tick(); ld(5'd7);
        tick(); ex(5'd7, 32'hAAAA); settle();
        chk("t3_waw_stall", {31'd0, bus.ex_ready_o}, 32'd0);
        tick(); ex(5'd3, 32'h3333); settle();
        chk("t3_other_rd", {31'd0, bus.ex_ready_o}, 32'd1);
        push_wr(5'd3, 32'h3333);
        tick(); ex(5'd3, 32'h4444); rsp(32'h7777, 1'b0); settle();
        chk("t3_rsp_blocks_ex", {31'd0, bus.ex_ready_o}, 32'd0);
        push_wr(5'd7, 32'h7777);
        tick(); ex(5'd3, 32'h4444); settle();
        chk("t3_ex_retry", {31'd0, bus.ex_ready_o}, 32'd1);
        push_wr(5'd3, 32'h4444);
        tick(); ex(5'd7, 32'hAAAA); settle();
        chk("t3_waw_retry", {31'd0, bus.ex_ready_o}, 32'd1);
        push_wr(5'd7, 32'hAAAA);

        // Load bus error: no write, one error pulse, back to IDLE.
        tick(); ld(5'd9);
        tick();
        tick(); rsp(32'hFFFF, 1'b1); settle();
        push_ev(EV_ERR);
        tick(); settle();
        chk("t4_ld_ready_after_err", {31'd0, bus.ld_ready_o}, 32'd1);
        chk("t4_load_err_pulse", {31'd0, bus.load_err_o}, 32'd1);
        tick(); settle();
        chk("t4_load_err_once", {31'd0, bus.load_err_o}, 32'd0);

        // Writes to x0 are accepted but never reach the write port.
        tick(); ex(5'd0, 32'h1234); settle();
        chk("t5_x0_ex_ready", {31'd0, bus.ex_ready_o}, 32'd1);
        tick(); ld(5'd0);
        tick(); ex(5'd0, 32'h9); bus.raddr_a_i = 5'd0; settle();
        chk("t5_x0_ld_pend", {31'd0, bus.ld_ready_o}, 32'd0);
        chk("t5_x0_ex_nostall", {31'd0, bus.ex_ready_o}, 32'd1);
        chk("t5_x0_no_hazard", {31'd0, bus.hazard_a_o}, 32'd0);
        tick(); rsp(32'h5555, 1'b0); settle();
        chk("t5_x0_rsp_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        tick(); settle();
        chk("t5_x0_no_we", {31'd0, bus.rf_we_o}, 32'd0);
        chk("t5_x0_idle", {31'd0, bus.ld_ready_o}, 32'd1);

        // RV32E drops x16-x31; the full-width instance writes them normally.
        tick();
        bus_e.ex_valid_i = 1'b1; bus_e.ex_waddr_i = 5'd20; bus_e.ex_wdata_i = 32'h1;
        ex(5'd20, 32'h2020);
        push_wr(5'd20, 32'h2020);
        tick();
        bus_e.ex_valid_i = 1'b1; bus_e.ex_waddr_i = 5'd5; bus_e.ex_wdata_i = 32'h55;
        settle();
        chk("t5_e_illegal", {31'd0, bus_e.illegal_waddr_o}, 32'd1);
        chk("t5_e_no_we", {31'd0, bus_e.rf_we_o}, 32'd0);
        tick(); settle();
        chk("t5_e_illegal_once", {31'd0, bus_e.illegal_waddr_o}, 32'd0);
        chk("t5_e_legal_we", {31'd0, bus_e.rf_we_o}, 32'd1);
        chk("t5_e_legal_addr", {27'd0, bus_e.rf_waddr_o}, 32'd5);
        tick(); tick();

        // Reset while a load is pending discards it.
        tick(); ld(5'd12);
        tick();
        rst_n = 1'b0;
        #3;
        chk("t6_rst_we", {31'd0, bus.rf_we_o}, 32'd0);
        chk("t6_rst_ld_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick(); rsp(32'hBAD, 1'b0); settle();
        chk("t6_stale_ld_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        chk("t6_stale_ex_ready", {31'd0, bus.ex_ready_o}, 32'd1);
        tick(); settle();
        chk("t6_stale_no_we", {31'd0, bus.rf_we_o}, 32'd0);

        // Back-to-back loads: response and new issue in the same cycle.
        tick(); ld(5'd10);
        tick();
        tick(); rsp(32'hA0A0, 1'b0); ld(5'd11); settle();
        chk("t6_b2b_ld_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        push_wr(5'd10, 32'hA0A0);
        tick(); bus.raddr_a_i = 5'd11; bus.raddr_b_i = 5'd10; ex(5'd11, 32'hCC); settle();
        chk("t6_b2b_still_pend", {31'd0, bus.ld_ready_o}, 32'd0);
        chk("t6_b2b_hazard_a", {31'd0, bus.hazard_a_o}, 32'd1);
        chk("t6_b2b_hazard_b", {31'd0, bus.hazard_b_o}, 32'd1);
        chk("t6_b2b_waw", {31'd0, bus.ex_ready_o}, 32'd0);
        tick(); rsp(32'hB1B1, 1'b0);
        push_wr(5'd11, 32'hB1B1);
        tick(); tick(); tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
